mem_stage_access: RTL

Memory-stage access controller: consumes the MEM-stage control, address and store data held in the EXE/MEM pipeline register and performs the load or store over a req/ack data-memory bus. It stalls the front of the pipeline while the access is outstanding (drives the EXE/MEM register `enable` low through `mem_stall`). It returns aligned, extended load data for the MEM/WB register. It aligns bytes and halfwords little-endian, detects misaligned and illegal accesses, and enforces a bus timeout.

---
 rtl/mem_stage_access_if.sv | 21 ++
 rtl/mem_stage_access.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_access_if.sv
// Data-memory request/acknowledge bus between the MEM-stage access
// controller (master) and the data memory (slave).
interface mem_stage_access_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_stage_access.sv
// MEM-stage load/store controller: issues one req/ack bus access per
// legal operation, stalls the pipeline meanwhile and returns extended load data.
module mem_stage_access #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  mem_ctrl_m,
  input  logic [31:0] aluout_m,
  input  logic [31:0] writedata_m,
  output logic        mem_stall,
  output logic [31:0] readdata_m,
  output logic        mem_err,
  output logic [1:0]  mem_err_cause,
  mem_stage_access_if.master dmem
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, WAIT_ACK, DONE} state_t;

  state_t        state_q, state_d;
  logic          req_q, req_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tout_q, tout_d;
  logic [1:0]    size_q, size_d;
  logic [1:0]    off_q, off_d;

  logic        op_rd, op_wr;
  logic [1:0]  op_size;
  logic        misaligned;
  logic [31:0] lane_word;
  logic [31:0] load_val;

  assign op_rd   = mem_ctrl_m[3];
  assign op_wr   = mem_ctrl_m[2];
  assign op_size = mem_ctrl_m[1:0];

  assign misaligned = ((op_size == 2'b00) && (aluout_m[1:0] != 2'b00)) ||
                      ((op_size == 2'b01) && aluout_m[0]);

  // Shift the addressed lane down to bit 0, then extend by size.
  assign lane_word = dmem.dmem_rdata >> {off_q, 3'b000};

  always_comb begin
    load_val = dmem.dmem_rdata;
    case (size_q)
      2'b01:   load_val = {{16{lane_word[15]}}, lane_word[15:0]};
      2'b10:   load_val = {{24{lane_word[7]}}, lane_word[7:0]};
      2'b11:   load_val = {24'h0, lane_word[7:0]};
      default: load_val = dmem.dmem_rdata;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    req_d         = req_q;
    we_d          = we_q;
    addr_d        = addr_q;
    be_d          = be_q;
    wdata_d       = wdata_q;
    rdata_d       = rdata_q;
    cnt_d         = cnt_q;
    tout_d        = tout_q;
    size_d        = size_q;
    off_d         = off_q;
    mem_stall     = 1'b0;
    mem_err       = 1'b0;
    mem_err_cause = 2'b00;

    case (state_q)
      IDLE: begin
        if (op_rd && op_wr) begin
          mem_err       = 1'b1;
          mem_err_cause = 2'b10;
        end else if (op_rd || op_wr) begin
          if (misaligned) begin
            mem_err       = 1'b1;
            mem_err_cause = 2'b01;
          end else begin
            mem_stall = 1'b1;
            req_d     = 1'b1;
            we_d      = op_wr;
            addr_d    = {aluout_m[31:2], 2'b00};
            size_d    = op_size;
            off_d     = aluout_m[1:0];
            cnt_d     = '0;
            tout_d    = 1'b0;
            state_d   = WAIT_ACK;
            case (op_size)
              2'b00: begin
                be_d    = 4'b1111;
                wdata_d = writedata_m;
              end
              2'b01: begin
                be_d    = aluout_m[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{writedata_m[15:0]}};
              end
              default: begin
                be_d    = 4'b0001 << aluout_m[1:0];
                wdata_d = {4{writedata_m[7:0]}};
              end
            endcase
          end
        end
      end

      WAIT_ACK: begin
        mem_stall = 1'b1;
        if (dmem.dmem_ack) begin
          req_d   = 1'b0;
          state_d = DONE;
          if (!we_q) begin
            rdata_d = load_val;
          end
        end else if (cnt_q == CNT_LAST) begin
          // Abandon the access; the error is reported from DONE.
          req_d   = 1'b0;
          rdata_d = 32'h0;
          tout_d  = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DONE: begin
        if (tout_q) begin
          mem_err       = 1'b1;
          mem_err_cause = 2'b11;
        end
        tout_d  = 1'b0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      be_q    <= 4'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      cnt_q   <= '0;
      tout_q  <= 1'b0;
      size_q  <= 2'b00;
      off_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      tout_q  <= tout_d;
      size_q  <= size_d;
      off_q   <= off_d;
    end
  end

  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_be    = be_q;
  assign dmem.dmem_wdata = wdata_q;
  assign readdata_m      = rdata_q;

endmodule
